mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single memory bus between the instruction-fetch port (IF) and the load/store port (MEM) of the 5-stage pipeline. It generates the `inst_mem_wait` and `data_mem_wait` signals consumed by the hazard unit to freeze the pipeline. It holds one outstanding bus transaction at a time. Under contention it gives priority to data and hands off to the other port on completion, so neither port can starve.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8` bits wide.

Ports:
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — reset, synchronous and active-low.
- `inst_req`  in  1  — IF read request. May drop at any time (pipeline flush).
- `inst_addr`  in  ADDR_W  — fetch address.
- `inst_rdata`  out  DATA_W  — fetched word. Valid only in the cycle `inst_req && !inst_mem_wait`.
- `inst_mem_wait`  out  1  — fetch not yet complete.
- `data_req`  in  1  — MEM access request. Must be held, with all fields stable, until `data_mem_wait` is low.
- `data_we`  in  1  — 1 selects write.
- `data_addr`  in  ADDR_W  — access address.
- `data_wdata`  in  DATA_W  — write data.
- `data_be`  in  DATA_W/8  — byte enables.
- `data_rdata`  out  DATA_W  — load data. Valid only in the cycle `data_req && !data_mem_wait` with `data_we=0`.
- `data_mem_wait`  out  1  — data access not yet complete.
- `bus_req`  out  1  — bus transaction active. Held high until `bus_ack`.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`  out  —  request fields, driven from internal registers.
- `bus_ack`  in  1  — single-cycle completion pulse. May arrive in the same cycle `bus_req` first rises.
- `bus_rdata`  in  DATA_W  — read data, valid with `bus_ack`.

## Operation
- States are `IDLE`, `INST` and `DATA`.
- `bus_req` = (state != `IDLE`). This is a registered-state decode.
- **Grant, from `IDLE`:**
  - `data_req` → `DATA`.
  - Otherwise `inst_req` → `INST`.
  - Otherwise stay in `IDLE`.
- **On grant:** capture the winning port's `addr` into `addr_q`. For data, also capture `we`, `wdata` and `be`. For instructions, `we_q=0` and `be_q` is all ones.
- **`DATA` + `bus_ack`:**
  - The data access completes.
  - Next state is `INST` if `inst_req`, else `IDLE`. This is the handoff.
- **`INST` + `bus_ack`:**
  - The access completes only if `inst_req && inst_addr == addr_q`. Otherwise the returned data is discarded as stale.
  - Next state is `DATA` if `data_req`, else `INST` if the inst request is still pending (stale case), else `IDLE`.
  - Any handoff or re-grant recaptures the fields.
- **Wait outputs:**
  - `inst_mem_wait` = `inst_req && !(state==INST && bus_ack && inst_addr==addr_q)`.
  - `data_mem_wait` = `data_req && !(state==DATA && bus_ack)`.
  - Both are 0 when the corresponding req is low.
- **Read data:** `inst_rdata` = `data_rdata` = `bus_rdata`, combinational pass-through. The pipeline captures it at the same edge at which its wait drops.
- **Fields while busy:** the `bus_*` fields do not change while state != `IDLE` and `bus_ack` is low.
- **Reset, including mid-transaction:**
  - state = `IDLE`, all capture registers = 0, `bus_req`=0 from the first cycle after the reset edge.
  - An abandoned bus transaction is dropped. The memory side must tolerate `bus_req` falling without `bus_ack`.

## Timing
- **Minimum latency:** 2 cycles per access. Req is seen in `IDLE` at cycle 0; `bus_req` goes high in cycle 1. With a same-cycle ack, wait is low in cycle 1.
- **Back-to-back alternating accesses:** 1 cycle each, because handoff skips `IDLE`.
- **Same port twice in a row:** costs one `IDLE` cycle between the accesses.
- **Sustained contention:** grants alternate D, I, D, I.
  - Each port waits at most one other access plus its own.
- **Inst request drops mid-transaction:** the bus transaction still runs to ack.
  - `inst_mem_wait` is already 0 because req is low.
  - The ack causes no completion.
- **New inst address before ack (flush then refetch):** the ack is treated as stale and `inst_mem_wait` stays 1.
  - If `data_req` is pending, the next state is `DATA` and the new fetch follows it.
  - Otherwise the new address is re-issued the following cycle.
- **`bus_ack` in `IDLE`:** ignored.

## Test plan
- **Reset:** assert `rst_n`=0 during an active `DATA` transaction, cycle 5 → cycle 6: `bus_req`=0 and both waits follow req only. After release, a fetch to 0x100 completes normally.
- **Single fetch:** ack latency 0, `inst_addr`=0x0000_0040, `bus_rdata`=0x0000_0013 → `bus_req` in cycle 1, `inst_mem_wait` low in cycle 1, `inst_rdata`=0x13, `bus_we`=0, `bus_be`=0xF.
- **Contention:** `inst_req` and `data_req` high together (data store 0xDEADBEEF to 0x2000, be=0x3), ack latency 2 → data issued first with exact fields. The handoff issues the fetch in the cycle after the data ack, with no `IDLE` cycle.
- **Fairness:** both ports request continuously for 8 accesses → grant order D, I, D, I, D, I, D, I. No wait exceeds 2 accesses.
- **Stale fetch:** fetch 0x80 issued; at ack `inst_addr` has changed to 0x200 → `inst_mem_wait` stays 1. The next transaction uses `bus_addr`=0x200 and completes with the new data.
- **Dropped fetch:** `inst_req` falls before ack → `inst_mem_wait`=0 throughout. The ack returns the state to `IDLE`, and a subsequent data load to 0x300 completes in 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-bus arbiter between the instruction-fetch and load/store ports.
// Data wins contention; completion hands the bus straight to the other port.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_rdata,
  output logic                  inst_mem_wait,

  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W/8-1:0]   data_be,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_mem_wait,

  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_be,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   be_q, be_d;

  logic inst_hit;
  logic data_done;

  // A fetch only completes if the pipeline still wants the address we issued.
  assign inst_hit  = (state_q == INST) && bus_ack && inst_req && (inst_addr == addr_q);
  assign data_done = (state_q == DATA) && bus_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;

    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d = DATA;
          we_d    = data_we;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          be_d    = data_be;
        end else if (inst_req) begin
          state_d = INST;
          we_d    = 1'b0;
          addr_d  = inst_addr;
          be_d    = '1;
        end
      end
      DATA: begin
        if (bus_ack) begin
          if (inst_req) begin
            state_d = INST;
            we_d    = 1'b0;
            addr_d  = inst_addr;
            be_d    = '1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      INST: begin
        if (bus_ack) begin
          if (data_req) begin
            state_d = DATA;
            we_d    = data_we;
            addr_d  = data_addr;
            wdata_d = data_wdata;
            be_d    = data_be;
          end else if (inst_req && !inst_hit) begin
            // Stale return: re-issue the fetch at whatever address is live now.
            state_d = INST;
            we_d    = 1'b0;
            addr_d  = inst_addr;
            be_d    = '1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_req   = (state_q != IDLE);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;

  assign inst_mem_wait = inst_req && !inst_hit;
  assign data_mem_wait = data_req && !data_done;

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, single fetch, contention,
// fairness, stale and dropped fetches, and reset during a live transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_mem_wait;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic [31:0] data_rdata;
  logic        data_mem_wait;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .inst_mem_wait (inst_mem_wait),
    .data_req      (data_req),
    .data_we       (data_we),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_be       (data_be),
    .data_rdata    (data_rdata),
    .data_mem_wait (data_mem_wait),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_be        (bus_be),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string order;
    logic  is_data;
    order = "DIDIDIDI";

    rst_n = 1'b0; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    applyStimulus(2);

    // Reset state
    checkOutput("rst_bus_req",   {31'b0, bus_req}, 32'h0);
    checkOutput("rst_bus_addr",  bus_addr, 32'h0);
    checkOutput("rst_bus_be",    {28'b0, bus_be}, 32'h0);
    checkOutput("rst_inst_wait", {31'b0, inst_mem_wait}, 32'h0);
    checkOutput("rst_data_wait", {31'b0, data_mem_wait}, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1);

    // Ack while idle is ignored
    bus_ack = 1'b1;
    applyStimulus(1);
    checkOutput("idle_ack_bus_req", {31'b0, bus_req}, 32'h0);
    bus_ack = 1'b0;

    // Single fetch with same-cycle ack
    inst_req = 1'b1; inst_addr = 32'h0000_0040; #1;
    checkOutput("sf_c0_bus_req",   {31'b0, bus_req}, 32'h0);
    checkOutput("sf_c0_inst_wait", {31'b0, inst_mem_wait}, 32'h1);
    applyStimulus(1);
    checkOutput("sf_c1_bus_req",  {31'b0, bus_req}, 32'h1);
    checkOutput("sf_c1_bus_addr", bus_addr, 32'h40);
    checkOutput("sf_c1_bus_we",   {31'b0, bus_we}, 32'h0);
    checkOutput("sf_c1_bus_be",   {28'b0, bus_be}, 32'hF);
    bus_ack = 1'b1; bus_rdata = 32'h0000_0013; #1;
    checkOutput("sf_c1_inst_wait", {31'b0, inst_mem_wait}, 32'h0);
    checkOutput("sf_c1_rdata",     inst_rdata, 32'h13);
    applyStimulus(1);
    inst_req = 1'b0; bus_ack = 1'b0; #1;
    checkOutput("sf_c2_bus_req", {31'b0, bus_req}, 32'h0);

    // Contention: data store first, ack latency 2, then handoff to fetch
    inst_req = 1'b1; inst_addr = 32'h44;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF; data_be = 4'h3;
    #1;
    checkOutput("ct_c0_data_wait", {31'b0, data_mem_wait}, 32'h1);
    applyStimulus(1);
    checkOutput("ct_c1_bus_addr",  bus_addr, 32'h2000);
    checkOutput("ct_c1_bus_we",    {31'b0, bus_we}, 32'h1);
    checkOutput("ct_c1_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    checkOutput("ct_c1_bus_be",    {28'b0, bus_be}, 32'h3);
    applyStimulus(1);
    checkOutput("ct_c2_bus_addr",  bus_addr, 32'h2000);
    checkOutput("ct_c2_data_wait", {31'b0, data_mem_wait}, 32'h1);
    applyStimulus(1);
    bus_ack = 1'b1; #1;
    checkOutput("ct_c3_data_wait", {31'b0, data_mem_wait}, 32'h0);
    checkOutput("ct_c3_inst_wait", {31'b0, inst_mem_wait}, 32'h1);
    applyStimulus(1);
    data_req = 1'b0; bus_ack = 1'b0; #1;
    checkOutput("ct_c4_bus_req",  {31'b0, bus_req}, 32'h1);
    checkOutput("ct_c4_bus_addr", bus_addr, 32'h44);
    checkOutput("ct_c4_bus_we",   {31'b0, bus_we}, 32'h0);
    checkOutput("ct_c4_bus_be",   {28'b0, bus_be}, 32'hF);
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222; #1;
    checkOutput("ct_c4_inst_wait", {31'b0, inst_mem_wait}, 32'h0);
    applyStimulus(1);
    inst_req = 1'b0; bus_ack = 1'b0; #1;
    checkOutput("ct_end_bus_req", {31'b0, bus_req}, 32'h0);

    // Fairness: both ports request continuously, every access acked at once
    inst_req = 1'b1; inst_addr = 32'h500;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3000; data_be = 4'hF;
    applyStimulus(1);
    for (int k = 0; k < 8; k++) begin
      is_data = (order[k] == "D");
      bus_ack = 1'b1; bus_rdata = 32'hA000 + k; #1;
      checkOutput($sformatf("fair%0d_bus_addr", k), bus_addr, is_data ? 32'h3000 : 32'h500);
      checkOutput($sformatf("fair%0d_data_wait", k), {31'b0, data_mem_wait}, is_data ? 32'h0 : 32'h1);
      checkOutput($sformatf("fair%0d_inst_wait", k), {31'b0, inst_mem_wait}, is_data ? 32'h1 : 32'h0);
      applyStimulus(1);
    end
    inst_req = 1'b0; #1;
    checkOutput("fair_tail_bus_addr",  bus_addr, 32'h3000);
    checkOutput("fair_tail_data_wait", {31'b0, data_mem_wait}, 32'h0);
    applyStimulus(1);
    data_req = 1'b0; bus_ack = 1'b0; #1;
    checkOutput("fair_end_bus_req", {31'b0, bus_req}, 32'h0);

    // Stale fetch: address changes before the ack
    inst_req = 1'b1; inst_addr = 32'h80;
    applyStimulus(1);
    checkOutput("st_bus_addr0", bus_addr, 32'h80);
    inst_addr = 32'h200; bus_ack = 1'b1; bus_rdata = 32'hBAD0_0080; #1;
    checkOutput("st_stale_wait", {31'b0, inst_mem_wait}, 32'h1);
    applyStimulus(1);
    bus_ack = 1'b0; #1;
    checkOutput("st_reissue_req",  {31'b0, bus_req}, 32'h1);
    checkOutput("st_reissue_addr", bus_addr, 32'h200);
    bus_ack = 1'b1; bus_rdata = 32'h0000_1234; #1;
    checkOutput("st_done_wait",  {31'b0, inst_mem_wait}, 32'h0);
    checkOutput("st_done_rdata", inst_rdata, 32'h1234);
    applyStimulus(1);
    inst_req = 1'b0; bus_ack = 1'b0; #1;
    checkOutput("st_end_bus_req", {31'b0, bus_req}, 32'h0);

    // Dropped fetch, then a data load completing in 2 cycles
    inst_req = 1'b1; inst_addr = 32'h90;
    applyStimulus(1);
    inst_req = 1'b0; #1;
    checkOutput("dr_wait_drop", {31'b0, inst_mem_wait}, 32'h0);
    checkOutput("dr_bus_req",   {31'b0, bus_req}, 32'h1);
    applyStimulus(1);
    bus_ack = 1'b1; #1;
    checkOutput("dr_ack_wait", {31'b0, inst_mem_wait}, 32'h0);
    applyStimulus(1);
    bus_ack = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300; data_be = 4'hF; #1;
    checkOutput("dr_idle_bus_req", {31'b0, bus_req}, 32'h0);
    checkOutput("dr_ld_wait_c0",   {31'b0, data_mem_wait}, 32'h1);
    applyStimulus(1);
    bus_ack = 1'b1; bus_rdata = 32'h0000_0055; #1;
    checkOutput("dr_ld_bus_addr", bus_addr, 32'h300);
    checkOutput("dr_ld_wait_c1",  {31'b0, data_mem_wait}, 32'h0);
    checkOutput("dr_ld_rdata",    data_rdata, 32'h55);
    applyStimulus(1);
    data_req = 1'b0; bus_ack = 1'b0; #1;

    // Reset in the middle of a data transaction
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h400; data_wdata = 32'h7777_7777;
    applyStimulus(1);
    checkOutput("mr_active_req", {31'b0, bus_req}, 32'h1);
    rst_n = 1'b0;
    applyStimulus(1);
    checkOutput("mr_bus_req",    {31'b0, bus_req}, 32'h0);
    checkOutput("mr_bus_addr",   bus_addr, 32'h0);
    checkOutput("mr_bus_wdata",  bus_wdata, 32'h0);
    checkOutput("mr_data_wait",  {31'b0, data_mem_wait}, 32'h1);
    checkOutput("mr_inst_wait",  {31'b0, inst_mem_wait}, 32'h0);
    rst_n = 1'b1; data_req = 1'b0; data_we = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h100; #1;
    checkOutput("mr_post_wait_c0", {31'b0, inst_mem_wait}, 32'h1);
    applyStimulus(1);
    checkOutput("mr_post_bus_addr", bus_addr, 32'h100);
    bus_ack = 1'b1; bus_rdata = 32'h0000_00AB; #1;
    checkOutput("mr_post_wait_c1", {31'b0, inst_mem_wait}, 32'h0);
    checkOutput("mr_post_rdata",   inst_rdata, 32'hAB);
    applyStimulus(1);
    inst_req = 1'b0; bus_ack = 1'b0; #1;
    checkOutput("mr_end_bus_req", {31'b0, bus_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
